intmul_arb_34x43: RTL and testbench

- Round-robin arbiter and scheduler that shares one pipelined intmul_nonstd_34x43 instance among N_REQ requesters.
- Accepts operand pairs over valid/ready handshakes and issues at most one multiply per cycle.
- Carries each requester ID alongside its product through the multiplier pipeline.
- Returns products in issue order through a credit-protected result FIFO with backpressure.

---
 rtl/intmul_arb_34x43.sv | 152 +++++++++++++++
 tb/tb_intmul_arb_34x43.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intmul_arb_34x43.sv
// Round-robin scheduler sharing one 3-stage pipelined multiplier among N_REQ requesters.
// Products return in issue order through a credit-protected first-word-fall-through FIFO.

module intmul_nonstd_34x43 #(
  parameter int LOGA = 34,
  parameter int LOGB = 43
) (
  input  logic                 clk,
  input  logic [LOGA-1:0]      a,
  input  logic [LOGB-1:0]      b,
  output logic [LOGA+LOGB-1:0] c
);
  localparam int PW = LOGA + LOGB;

  // Input, multiply and output register stages; no reset, tags qualify the data.
  logic [LOGA-1:0] a_q;
  logic [LOGB-1:0] b_q;
  logic [PW-1:0]   p_q;
  logic [PW-1:0]   c_q;

  always_ff @(posedge clk) begin
    a_q <= a;
    b_q <= b;
    p_q <= PW'(a_q) * PW'(b_q);
    c_q <= p_q;
  end

  assign c = c_q;
endmodule

module intmul_arb_34x43 #(
  parameter int N_REQ      = 4,
  parameter int LOGA       = 34,
  parameter int LOGB       = 43,
  parameter int FIFO_DEPTH = 5,
  localparam int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*LOGA-1:0]   req_a,
  input  logic [N_REQ*LOGB-1:0]   req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [LOGA+LOGB-1:0]    res_c,
  output logic [IDW-1:0]          res_id,
  output logic                    busy
);
  localparam int MUL_LAT = 3;
  localparam int PW      = LOGA + LOGB;
  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam int PTRW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [CW-1:0]   cnt;
  logic [IDW-1:0]  rr_ptr;
  logic            grant_vld;
  logic [IDW-1:0]  gnt;
  logic            issue;
  logic            push;
  logic            pop;
  logic [LOGA-1:0] mul_a;
  logic [LOGB-1:0] mul_b;
  logic [PW-1:0]   mul_c;

  // Search order starts at rr_ptr; credits are judged on the registered count only.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    gnt       = '0;
    idx       = 0;
    if (!rst && (cnt < CW'(FIFO_DEPTH))) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!grant_vld && req_valid[idx]) begin
          grant_vld = 1'b1;
          gnt       = IDW'(idx);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++)
      req_ready[i] = grant_vld && (int'(gnt) == i);
  end

  assign issue = grant_vld;
  assign mul_a = req_a[int'(gnt)*LOGA +: LOGA];
  assign mul_b = req_b[int'(gnt)*LOGB +: LOGB];

  intmul_nonstd_34x43 #(.LOGA(LOGA), .LOGB(LOGB)) u_mul (
    .clk (clk),
    .a   (mul_a),
    .b   (mul_b),
    .c   (mul_c)
  );

  // vld_pipe[k] holds the tag of the operand pair issued k cycles ago.
  logic [MUL_LAT:1]           vld_pipe;
  logic [MUL_LAT:1][IDW-1:0]  id_pipe;

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[MUL_LAT-1:1], issue};
    id_pipe <= {id_pipe[MUL_LAT-1:1], gnt};
  end

  assign push = vld_pipe[MUL_LAT];

  logic [PW-1:0]   mem_c  [FIFO_DEPTH];
  logic [IDW-1:0]  mem_id [FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]   fcnt;
  logic            full;

  assign full      = (fcnt == CW'(FIFO_DEPTH));
  assign res_valid = !rst && (fcnt != '0);
  assign pop       = res_valid && res_ready;
  assign res_c     = mem_c[rd_ptr];
  assign res_id    = mem_id[rd_ptr];
  assign busy      = !rst && (cnt != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_c[wr_ptr]  <= mul_c;
      mem_id[wr_ptr] <= id_pipe[MUL_LAT];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTRW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTRW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      fcnt <= fcnt + 1'b1;
      else if (!push && pop) fcnt <= fcnt - 1'b1;
      if (issue && !pop)      cnt <= cnt + 1'b1;
      else if (!issue && pop) cnt <= cnt - 1'b1;
      if (issue) rr_ptr <= (int'(gnt) == N_REQ-1) ? '0 : gnt + 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

// File: tb/tb_intmul_arb_34x43.sv
// Randomized plus directed bench; a queue-based model predicts handshakes and results every cycle.
module tb_intmul_arb_34x43;
  localparam int N = 4;
  localparam int LA = 34;
  localparam int LB = 43;
  localparam int PW = LA + LB;
  localparam int DEPTH = 5;
  localparam int LAT = 4;   // issue cycle to first cycle res_valid can be seen

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*LA-1:0] req_a;
  logic [N*LB-1:0] req_b;
  logic            res_valid, res_ready;
  logic [PW-1:0]   res_c;
  logic [1:0]      res_id;
  logic            busy;

  int checks = 0;
  int errors = 0;

  intmul_arb_34x43 dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_c(res_c), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int t; logic [PW-1:0] p; int id; } ent_t;
  ent_t q[$];
  int   rr_m = 0;
  int   cyc = 0;
  bit   armed = 0;

  always @(negedge clk) begin
    logic [N-1:0] er;
    bit ev, eb;
    int g;
    ent_t e;
    if (rst) armed = 1;
    if (armed) begin
      er = '0; g = -1;
      ev = !rst && q.size() > 0 && (cyc - q[0].t >= LAT);
      eb = !rst && q.size() != 0;
      if (!rst && q.size() < DEPTH)
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(rr_m + k) % N]) g = (rr_m + k) % N;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", 128'(req_ready), 128'(er));
      chk("res_valid", 128'(res_valid), 128'(ev));
      chk("busy", 128'(busy), 128'(eb));
      if (ev) begin
        chk("res_c", 128'(res_c), 128'(q[0].p));
        chk("res_id", 128'(res_id), 128'(q[0].id));
      end
      if (rst) begin
        q.delete();
        rr_m = 0;
      end else begin
        if (ev && res_ready) void'(q.pop_front());
        if (g >= 0) begin
          e.t  = cyc;
          e.p  = {43'd0, req_a[g*LA +: LA]} * {34'd0, req_b[g*LB +: LB]};
          e.id = g;
          q.push_back(e);
          rr_m = (g + 1) % N;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [LA-1:0] a, input logic [LB-1:0] b);
    req_a[i*LA +: LA] = a;
    req_b[i*LB +: LB] = b;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  int xfers;

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_res_valid", 128'(res_valid), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));

    // single request, full-scale operands
    step();
    set_op(2, 34'h3_FFFF_FFFF, 43'h7FF_FFFF_FFFF);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single_grant", 128'(req_ready), 128'(4'b0100));
    for (int k = 1; k <= 4; k++) begin
      step();
      req_valid = '0;
      @(negedge clk);
      if (k == 3) chk("single_early", 128'(res_valid), 128'(0));
    end
    chk("single_valid", 128'(res_valid), 128'(1));
    chk("single_c", 128'(res_c), 128'(77'h1FFF_FFFF_F7FC_0000_0001));
    chk("single_id", 128'(res_id), 128'(2));
    idle(4);

    // round-robin streaming
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 34'(i + 1), 43'd10);
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", 128'(req_ready), 128'(4'b0001 << (k % 4)));
      if (k >= 4) begin
        chk("rr_c", 128'(res_c), 128'(10 * (k - 3)));
        chk("rr_id", 128'(res_id), 128'(k - 4));
      end
      step();
    end
    idle(10);

    // backpressure
    res_ready = 1'b0; xfers = 0;
    set_op(0, 34'd7, 43'd9); set_op(1, 34'd11, 43'd13);
    req_valid = 4'b0011;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ((req_ready & req_valid) != 0) xfers++;
      step();
    end
    chk("bp_xfers", 128'(xfers), 128'(DEPTH));
    chk("bp_busy", 128'(busy), 128'(1));
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_noissue", 128'(req_ready), 128'(0));
    step();
    res_ready = 1'b0; xfers = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if ((req_ready & req_valid) != 0) xfers++;
      chk("bp_busy_hold", 128'(busy), 128'(1));
      step();
    end
    chk("bp_admit_one", 128'(xfers), 128'(1));
    res_ready = 1'b1;
    idle(12);

    // fairness
    do_reset();
    req_valid = 4'b0010;
    @(negedge clk);
    chk("fair_first", 128'(req_ready), 128'(4'b0010));
    step();
    req_valid = 4'b1010;
    @(negedge clk);
    chk("fair_3", 128'(req_ready), 128'(4'b1000));
    step();
    @(negedge clk);
    chk("fair_1", 128'(req_ready), 128'(4'b0010));
    step();
    req_valid = 4'b1111;
    @(negedge clk);
    chk("fair_next", 128'(req_ready), 128'(4'b0100));
    step();
    idle(10);

    // reset with 3 in flight and 1 buffered
    res_ready = 1'b0;
    req_valid = '1;
    for (int k = 0; k < 4; k++) step();
    req_valid = '0; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 128'(res_valid), 128'(0));
    chk("rst_mid_ready", 128'(req_ready), 128'(0));
    step();
    rst = 1'b0; res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_no_stale", 128'({res_valid, busy}), 128'(0));
      step();
    end
    req_valid = '1;
    @(negedge clk);
    chk("rst_grant0", 128'(req_ready), 128'(4'b0001));
    step();
    idle(10);

    // corner operands
    set_op(0, 34'd0, 43'h5A5_A5A5_A5A5);
    req_valid = 4'b0001;
    step();
    set_op(0, 34'd1, 43'h400_0000_0000);
    step();
    req_valid = '0;
    step(); step();
    @(negedge clk);
    chk("corner_zero", 128'(res_c), 128'(0));
    step();
    @(negedge clk);
    chk("corner_pow2", 128'(res_c), 128'(77'h400_0000_0000));
    idle(6);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      req_valid = N'($urandom);
      res_ready = ($urandom_range(0, 3) != 0) || (k % 200 < 100 && $urandom_range(0, 1) == 1);
      if (k % 500 > 400) res_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 7))
          0:       set_op(i, '1, '1);
          1:       set_op(i, '0, LB'({$urandom, $urandom}));
          default: set_op(i, LA'({$urandom, $urandom}), LB'({$urandom, $urandom}));
        endcase
      end
      step();
    end
    rst = 1'b0; res_ready = 1'b1;
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
